// File: rtl/hex_display_scheduler.sv
// -----------------------------------------------------------------------------
// hex_display_scheduler
//
// Time-shares one 8-digit hex display between NUM_SRC 32-bit sources. One
// source is shown at a time; every switch blanks the display (through the
// driver's reset input) for BLANK_CYCLES clocks. Rotation is driven by a dwell
// timer (auto_en) and/or by rising edges on next_req. Invalid sources are
// skipped.
//
// Ports:
//   clk            rising-edge system clock
//   reset          synchronous, active-high; dominates every state
//   src_data       packed sources, source i at [32*i+31:32*i]
//   src_valid      per-source eligibility
//   auto_en        enable dwell-timer rotation
//   hold           freeze the dwell timer (manual advance still works)
//   next_req       debounced level; rising edge requests an advance
//   number         value for the display driver
//   disp_blank     1 = display blanked (driver held in reset)
//   src_sel        index of the source currently shown
//   update_strobe  one-cycle pulse when a new source is latched
// -----------------------------------------------------------------------------
module hex_display_scheduler #(
    parameter int  NUM_SRC      = 4,
    parameter int  DWELL_CYCLES = 50000000,
    parameter int  BLANK_CYCLES = 2500000,
    parameter int  CNT_W        = 26,
    localparam int SEL_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [32*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic                 auto_en,
    input  logic                 hold,
    input  logic                 next_req,
    output logic [31:0]          number,
    output logic                 disp_blank,
    output logic [SEL_W-1:0]     src_sel,
    output logic                 update_strobe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_SRC - 1);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   target, target_nx, src_sel_nx;
    logic [31:0]        number_q, number_nx;
    logic [CNT_W-1:0]   blank_cnt, blank_cnt_nx;
    logic [CNT_W-1:0]   dwell_cnt, dwell_cnt_nx;
    logic               next_prev;
    logic               advance_req, dwell_exp, trigger, any_valid;
    logic [SEL_W-1:0]   sel_plus1, fwd_idx, incl_idx;

    logic [31:0] src_word [NUM_SRC];
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_word[i] = src_data[32*i +: 32];
    end

    // First valid index at or after 'start', wrapping. Scanning downward and
    // overwriting leaves the nearest hit; 'start' itself is the last resort.
    function automatic logic [SEL_W-1:0] first_valid(input logic [SEL_W-1:0]   start,
                                                      input logic [NUM_SRC-1:0] valid);
        logic [SEL_W-1:0] pick;
        logic [SEL_W:0]   idx;
        pick = start;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = {1'b0, start} + (SEL_W+1)'(k);
            if (idx >= (SEL_W+1)'(NUM_SRC)) idx = idx - (SEL_W+1)'(NUM_SRC);
            if (valid[idx[SEL_W-1:0]]) pick = idx[SEL_W-1:0];
        end
        return pick;
    endfunction

    assign any_valid   = |src_valid;
    assign sel_plus1   = (src_sel == SEL_LAST) ? '0 : src_sel + SEL_W'(1);
    assign fwd_idx     = first_valid(sel_plus1, src_valid);
    assign incl_idx    = first_valid(src_sel, src_valid);
    assign advance_req = next_req & ~next_prev;
    assign dwell_exp   = auto_en & ~hold & (dwell_cnt == DWELL_LAST);
    assign trigger     = advance_req | dwell_exp | ~src_valid[src_sel];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state     <= IDLE;
            src_sel   <= '0;
            target    <= '0;
            number_q  <= '0;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            next_prev <= 1'b0;
        end else begin
            state     <= state_nx;
            src_sel   <= src_sel_nx;
            target    <= target_nx;
            number_q  <= number_nx;
            blank_cnt <= blank_cnt_nx;
            dwell_cnt <= dwell_cnt_nx;
            next_prev <= next_req;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned (no latches).
        state_nx      = state;
        target_nx     = target;
        src_sel_nx    = src_sel;
        number_nx     = number_q;
        blank_cnt_nx  = blank_cnt;
        dwell_cnt_nx  = dwell_cnt;
        number        = number_q;
        disp_blank    = 1'b1;
        update_strobe = 1'b0;

        case (state)
            IDLE: begin
                if (any_valid) begin
                    target_nx    = incl_idx;
                    blank_cnt_nx = BLANK_LOAD;
                    state_nx     = BLANK;
                end
            end

            BLANK: begin
                if (blank_cnt == '0) begin
                    // The new value is presented in the last blank cycle,
                    // together with the strobe, and registered for SHOW.
                    number        = src_word[target];
                    number_nx     = src_word[target];
                    src_sel_nx    = target;
                    update_strobe = 1'b1;
                    dwell_cnt_nx  = '0;
                    state_nx      = SHOW;
                end else begin
                    blank_cnt_nx = blank_cnt - CNT_W'(1);
                end
            end

            SHOW: begin
                disp_blank = 1'b0;
                number_nx  = src_word[src_sel];
                if (trigger) begin
                    dwell_cnt_nx = '0;
                    if (!any_valid) begin
                        state_nx = IDLE;
                    end else if (fwd_idx != src_sel) begin
                        target_nx    = fwd_idx;
                        blank_cnt_nx = BLANK_LOAD;
                        state_nx     = BLANK;
                    end
                end else if (!auto_en) begin
                    dwell_cnt_nx = '0;
                end else if (!hold) begin
                    dwell_cnt_nx = dwell_cnt + CNT_W'(1);
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
Time-shares the single 8-digit hex display between up to NUM_SRC 32-bit ALU values (operand A, operand B, result, status). It selects one source at a time, drives the display's number input, and blanks the display through its reset input during every switch. Rotation is automatic on a dwell timer, or manual via a next-request input. Sits between the ALU top level and the hex display driver.

Parameters:
NUM_SRC, 4, number of selectable 32-bit sources (2..8)
DWELL_CYCLES, 50000000, clock cycles each source is shown in auto mode (1 s @ 50 MHz)
BLANK_CYCLES, 2500000, clock cycles the display is blanked on each switch (50 ms); must be >=1
CNT_W, 26, counter width; must hold max(DWELL_CYCLES, BLANK_CYCLES)

Ports:
clk  in  1  50 MHz system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
src_data  in  32*NUM_SRC  packed sources; source i is bits [32*i+31:32*i]
src_valid  in  NUM_SRC  source i is eligible for display when 1
auto_en  in  1  enables dwell-timer rotation
hold  in  1  freezes the dwell timer; manual advance is still honoured
next_req  in  1  level input (debounced upstream); its rising edge requests an advance
number  out  32  value for the display driver
disp_blank  out  1  drives the display driver reset; 1 = all segments off
src_sel  out  SEL_W  index shown; SEL_W = max(1, clog2(NUM_SRC))
update_strobe  out  1  one-cycle pulse when a new source is latched

Behaviour:
- Reset (synchronous, dominates everything, including mid-BLANK or mid-SHOW): state=IDLE, src_sel=0, number=0, disp_blank=1, update_strobe=0, counters=0, next_req edge register=0.
- Edge detect: next_prev is registered each cycle; advance_req = next_req & ~next_prev.
- Next-valid search: from index src_sel+1 upward with wrap-around, return the first i with src_valid[i]=1. src_sel itself is checked last.
- IDLE: disp_blank=1 and number holds its last value. When any src_valid bit is set, search from src_sel inclusive, load the target, load blank_cnt=BLANK_CYCLES-1, and go to BLANK.
- BLANK: disp_blank=1. blank_cnt decrements. At 0: number<=src_data[target], src_sel<=target, update_strobe=1 for that cycle, dwell_cnt<=0, go to SHOW. BLANK lasts exactly BLANK_CYCLES cycles.
  - advance_req is ignored in BLANK.
  - If the target's src_valid drops during BLANK, the value is still latched; the SHOW rules handle it on the next cycle.
- SHOW: disp_blank=0. number<=src_data[src_sel] every cycle (live tracking, 1-cycle latency).
  - dwell_cnt increments when auto_en=1 and hold=0. dwell_cnt holds when hold=1. dwell_cnt clears when auto_en=0.
  - dwell_exp means dwell_cnt == DWELL_CYCLES-1 while counting.
- Advance trigger in SHOW: advance_req, dwell_exp, or src_valid[src_sel]=0. Simultaneous triggers produce one advance.
  - If no source is valid: go to IDLE.
  - If a different valid source exists: go to BLANK with that target.
  - If only src_sel is valid: stay in SHOW with no blank and no strobe, and clear dwell_cnt.
- Latency: a next_req rising edge sampled in cycle t gives disp_blank=1 from t+1. The new number and update_strobe appear at t+BLANK_CYCLES. disp_blank returns to 0 at t+BLANK_CYCLES+1.
- The counter must not wrap: dwell_cnt clears on every advance and never exceeds DWELL_CYCLES-1.

Test Plan:
(Bench uses NUM_SRC=4, DWELL_CYCLES=8, BLANK_CYCLES=2.)
1. Reset mid-BLANK → next cycle: number=0, disp_blank=1, src_sel=0, state IDLE. Release with src_valid=4'b1111 → BLANK for 2 cycles, then number=src_data[0], one update_strobe pulse.
2. auto_en=1, all sources valid, src_data values 0x11111111/0x22222222/0x33333333/0x44444444 → each shown for 8 cycles, then 2 blank cycles. src_sel sequence is 0,1,2,3,0 (wraps).
3. auto_en=0, next_req held high for 5 cycles in SHOW on source 1 → exactly one advance to source 2. A further next_req during BLANK is ignored.
4. src_valid=4'b0101 while showing source 0, advance → goes to source 2, skipping 1. Then drop src_valid[2] → immediate blank, back to source 0. Then src_valid=0 → IDLE with disp_blank=1.
5. hold=1 for 20 cycles with auto_en=1 → src_sel unchanged. Release hold → advance after the remaining dwell count. next_req rising on the same cycle as dwell_exp → a single advance only.
6. Only source 3 valid with auto_en=1 → src_sel stays 3, disp_blank stays 0, and no update_strobe after the first. Changing src_data[3] to 0xDEADBEEF → number shows 0xDEADBEEF one cycle later.
